// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the ASCII-hex instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_SETTLE} state_e;

  typedef enum logic [1:0] {CLS_HEX, CLS_SEP, CLS_TERM, CLS_BAD} byte_class_e;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_TERM = 8'h23;

  localparam int NIBBLES_PER_WORD = 8;

endpackage

// File: rtl/ascii_hex_decoder.sv
// Combinational byte classifier: hex digit (either case), separator, terminator or invalid.
module ascii_hex_decoder
  import imem_loader_pkg::*;
(
  input  logic [7:0]  byte_i,
  output byte_class_e cls_o,
  output logic [3:0]  nib_o
);

  always_comb begin
    cls_o = CLS_BAD;
    nib_o = 4'h0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      cls_o = CLS_HEX;
      nib_o = byte_i[3:0];
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      cls_o = CLS_HEX;
      nib_o = byte_i[3:0] + 4'd9;
    end else if (byte_i == ASCII_SP || byte_i == ASCII_CR || byte_i == ASCII_LF) begin
      cls_o = CLS_SEP;
    end else if (byte_i == ASCII_TERM) begin
      cls_o = CLS_TERM;
    end
  end

endmodule

// File: rtl/imem_hex_loader.sv
// Decodes a UART ASCII-hex stream into 32-bit words written to instruction memory.
// Define LOADER_ECHO_EN to echo accepted bytes and gate acceptance on tx_busy.
module imem_hex_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_clr,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      LAST_NIB = 4'(NIBBLES_PER_WORD - 1);

  state_e            state_q, state_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [3:0]        nib_cnt_q, nib_cnt_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              done_q, done_d, err_q, err_d;
  logic              rx_clr_q, rx_clr_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              accept, full;
  byte_class_e       cls;
  logic [3:0]        nib;

  ascii_hex_decoder u_dec (
    .byte_i (rx_data),
    .cls_o  (cls),
    .nib_o  (nib)
  );

  assign full = (word_count_q == CAP);

`ifdef LOADER_ECHO_EN
  logic       tx_wr_q;
  logic [7:0] tx_data_q;
  assign accept  = (state_q == S_IDLE) && load_en && rx_valid && !tx_busy;
  assign tx_wr   = tx_wr_q;
  assign tx_data = tx_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !load_en) begin
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_wr_q <= accept;
      if (accept) tx_data_q <= rx_data;
    end
  end
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign accept  = (state_q == S_IDLE) && load_en && rx_valid;
  assign tx_wr   = 1'b0;
  assign tx_data = 8'h00;
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    nib_cnt_d    = nib_cnt_q;
    wr_pend_d    = wr_pend_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    err_d        = err_q;
    rx_clr_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d   = S_ACK;
        rx_clr_d  = 1'b1;
        wr_pend_d = 1'b0;
        // full also blocks decode in the one cycle before done registers
        if (!done_q && !full) begin
          unique case (cls)
            CLS_HEX: begin
              shreg_d   = {shreg_q[27:0], nib};
              nib_cnt_d = nib_cnt_q + 4'd1;
              wr_pend_d = (nib_cnt_q == LAST_NIB);
            end
            CLS_SEP: if (nib_cnt_q != 4'd0) begin
              nib_cnt_d = 4'd0;
              err_d     = 1'b1;
            end
            CLS_TERM: begin
              done_d = 1'b1;
              if (nib_cnt_q != 4'd0) begin
                nib_cnt_d = 4'd0;
                err_d     = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_ACK: begin
        state_d = S_SETTLE;
        if (wr_pend_q) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_count_q[ADDR_W-1:0];
          mem_wdata_d = shreg_q;
        end
      end
      S_SETTLE: begin
        state_d   = S_IDLE;
        wr_pend_d = 1'b0;
        if (mem_we_q) begin
          word_count_d = word_count_q + (ADDR_W+1)'(1);
          nib_cnt_d    = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (full) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !load_en) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      nib_cnt_q    <= '0;
      wr_pend_q    <= 1'b0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rx_clr_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      nib_cnt_q    <= nib_cnt_d;
      wr_pend_q    <= wr_pend_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rx_clr_q     <= rx_clr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign rx_clr     = rx_clr_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/imem_hex_loader.md
# imem_hex_loader

Upstream feeder for the CPU instruction memory. Consumes bytes from the UART receiver, decodes an ASCII-hex stream into 32-bit instruction words (MSB nibble first), and writes each completed word to consecutive instruction-memory addresses. It optionally echoes every accepted byte back through the UART transmitter. It is active only while the CPU is held stopped (`load_en` high), and it reports progress and errors to the top level.

## Interface
- `ADDR_W`, default 4: instruction-memory address width; capacity is 2**ADDR_W words.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load_en`  in  1  loader enable. High means the CPU is stopped. Low means a synchronous soft clear (same effect as reset).
- `rx_data`  in  8  received byte from the UART.
- `rx_valid`  in  1  UART byte-ready flag; it stays high until cleared.
- `rx_clr`  out  1  one-cycle pulse that clears `rx_valid` in the UART.
- `tx_data`  out  8  echo byte.
- `tx_wr`  out  1  one-cycle transmit strobe.
- `tx_busy`  in  1  transmitter busy.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  write data.
- `word_count`  out  ADDR_W+1  number of words written since clear.
- `done`  out  1  sticky: terminator received or memory full.
- `err`  out  1  sticky: an invalid character or a truncated word was seen.

## Operation
- **Byte classes:**
  - Hex digit: `0x30`–`0x39`, `0x41`–`0x46`, `0x61`–`0x66`. Lowercase digits are accepted.
  - Separator: `0x20`, `0x0D`, `0x0A`.
  - Terminator: `#` (`0x23`).
  - Anything else is invalid.
- **States:** IDLE, ACK, SETTLE.
  - IDLE → ACK on accept.
  - ACK → SETTLE unconditionally.
  - SETTLE → IDLE unconditionally.
- **Accept condition:** state IDLE, `load_en`=1, `rx_valid`=1, and (`tx_busy`=0 when echo is built in).
- **Hex digit:** `shreg <= {shreg[27:0], nib}`; `nib_cnt`++. When `nib_cnt` reaches 8, the word is complete.
- **Separator:**
  - Ignored when `nib_cnt` is 0.
  - With a partial word (1–7 nibbles): the partial word is discarded, `nib_cnt`=0, and `err`=1.
- **Terminator:** `done`=1. Any partial word is discarded and also sets `err`.
- **Invalid byte:** the byte is dropped and `err`=1. `shreg` and `nib_cnt` are unchanged.
- **Word completion:** `mem_we` pulses with `mem_addr` = `word_count[ADDR_W-1:0]` and `mem_wdata` = `shreg`. Then `word_count`++ and `nib_cnt` clears to 0.
- **Full:** when `word_count` = 2**ADDR_W, `done`=1.
- **When `done`=1:**
  - Further bytes are still consumed (`rx_clr`, echo).
  - They cause no decode and no writes.
  - `err` is not updated.
- **Reset or `load_en`=0:**
  - State returns to IDLE.
  - `shreg`, `nib_cnt`, `word_count`, `done`, and `err` clear to 0.
  - Any partial word is lost.
  - No `rx_clr` is issued, so a pending byte stays in the UART.

## Timing
- All outputs are registered.
- **Reset values:** 0 for `rx_clr`, `tx_wr`, `tx_data`, `mem_we`, `mem_addr`, `mem_wdata`, `word_count`, `done`, and `err`.
- **Accept at edge T:**
  - Cycle T+1 (ACK): `rx_clr`=1, `tx_wr`=1, `tx_data`=byte; `shreg`, `nib_cnt`, `err`, and `done` are updated.
  - Cycle T+2 (SETTLE): `mem_we`=1 if the word completed; `word_count` increments at the end of T+2.
  - The earliest next accept is edge T+3. This covers the UART's registered clear, so a byte is never double-accepted.
- **Write latency:** 2 cycles from accepting the 8th nibble to `mem_we`.
- **Pulse widths:** `mem_we`, `rx_clr`, and `tx_wr` are each exactly one cycle.
- `mem_addr` and `mem_wdata` are valid only while `mem_we`=1.
- **`done` timing:** for the terminator, `done` rises in T+1. For the full condition, it rises the cycle after the last `word_count` increment.
- **`load_en` falling mid-ACK/SETTLE:** the clear wins, and no `mem_we` is issued.

## Configuration
- `LOADER_ECHO_EN`
  - **Defined:** every accepted byte is echoed (`tx_wr`/`tx_data`), and acceptance waits for `tx_busy`=0.
  - **Undefined:** `tx_wr` and `tx_data` are tied to 0, `tx_busy` is ignored, and acceptance depends only on `rx_valid` and state.

## Structure
- **Package `imem_loader_pkg`:**
  - State enum (IDLE/ACK/SETTLE).
  - ASCII constants (separators, terminator `0x23`).
  - `NIBBLES_PER_WORD` = 8.
  - Byte-class enum (HEX/SEP/TERM/BAD).
- **Sub-module `ascii_hex_decoder`:** combinational; `rx_data` in, byte class plus 4-bit nibble out.

## Test plan
- **Basic write:** send "DEADBEEF" then LF → one `mem_we` with addr 0, data `0xDEADBEEF`; `word_count`=1; `err`=0.
- **Lowercase and echo:** send "00a00093 00100113" with echo built in → addr 0 = `0x00A00093`, addr 1 = `0x00100113`; 17 `tx_wr` pulses echoing identical bytes, each issued only while `tx_busy`=0.
- **Bad input:** send "12G4" then space → `err`=1; no `mem_we`; `nib_cnt` back at 0. The next "FFFFFFFF" writes addr 0.
- **Fill to capacity:** `ADDR_W`=4; send 17 valid words → exactly 16 writes to addr 0..15; `done`=1 after the 16th; the 17th word is consumed with no write.
- **Terminator and soft clear:** send "1234#" → `done`=1, `err`=1, no write. Drop `load_en` for one cycle → `done`=0, `err`=0, `word_count`=0.
- **Held `rx_valid`:** keep `rx_valid` high across ACK/SETTLE with one byte → exactly one accept, one `rx_clr`, and a gap of at least 3 cycles between accepts.
